// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with optional hold-limit preemption.
// The grant outputs, owner index and valid flag are all decoded from the
// same state/owner registers, so they can never disagree with each other.
module bus_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1)
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       m0_req_i,
  input  logic       m1_req_i,
  input  logic       m2_req_i,
  input  logic       m3_req_i,
  input  logic       bus_rdy_i,
  output logic       m0_grnt_o,
  output logic       m1_grnt_o,
  output logic       m2_grnt_o,
  output logic       m3_grnt_o,
  output logic [1:0] grnt_idx_o,
  output logic       grnt_vld_o
);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_t           state_q;
  logic [1:0]       owner_q;
  logic [1:0]       last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [3:0] req;
  logic [3:0] othersReq;
  logic       ownerReq;
  logic       anyReq;
  logic       anyOther;
  logic       preempt;
  logic [1:0] winAll;
  logic [1:0] winOther;

  // First requesting master found scanning upward from just after 'from',
  // wrapping mod 4; 'from' itself is the last position examined.
  function automatic logic [1:0] rrPick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = from;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = from + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign req       = {m3_req_i, m2_req_i, m1_req_i, m0_req_i};
  assign othersReq = req & ~(4'b0001 << owner_q);
  assign ownerReq  = req[owner_q];
  assign anyReq    = |req;
  assign anyOther  = |othersReq;

  // Winner selection and hold-limit bookkeeping for the current cycle.
  // The owner is masked out for hand-overs, which makes a release and a
  // preemption use exactly the same winner computation.
  always_comb begin
    winAll   = rrPick(req, last_q);
    winOther = rrPick(othersReq, owner_q);
    preempt  = (HOLD_MAX != 0) && (cnt_q == HOLD_LIM) && anyOther && bus_rdy_i;
    cnt_d    = (cnt_q == HOLD_LIM) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Arbitration FSM: grant from IDLE, hold while the owner requests, and
  // hand over on release or at a transfer boundary once the limit is hit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            state_q <= OWNED;
            owner_q <= winAll;
            last_q  <= winAll;
            cnt_q   <= '0;
          end
        end
        OWNED: begin
          if (!ownerReq || preempt) begin
            cnt_q <= '0;
            if (anyOther) begin
              owner_q <= winOther;
              last_q  <= winOther;
            end else begin
              state_q <= IDLE;
            end
          end else if (anyOther) begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign grnt_vld_o = (state_q == OWNED);
  assign grnt_idx_o = owner_q;
  assign m0_grnt_o  = grnt_vld_o && (owner_q == 2'd0);
  assign m1_grnt_o  = grnt_vld_o && (owner_q == 2'd1);
  assign m2_grnt_o  = grnt_vld_o && (owner_q == 2'd2);
  assign m3_grnt_o  = grnt_vld_o && (owner_q == 2'd3);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: one instance with HOLD_MAX=4 and one with
// preemption disabled, both driven by the same inputs and compared against
// a list-based reference model of the arbitration rules.
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rdy;

  logic [3:0] g4;
  logic [1:0] idx4;
  logic       vld4;
  logic [3:0] g0;
  logic [1:0] idx0;
  logic       vld0;

  int total;
  int bad;

  // Model state per instance: index 0 is HOLD_MAX=4, index 1 is HOLD_MAX=0.
  int mOwner[2];
  int mLast[2];
  int mCnt[2];
  int holdMax[2];

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    int         expOwner;
  } vec_t;

  vec_t vecs[7];

  bus_arbiter #(.HOLD_MAX(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(req[0]), .m1_req_i(req[1]), .m2_req_i(req[2]), .m3_req_i(req[3]),
    .bus_rdy_i(rdy),
    .m0_grnt_o(g4[0]), .m1_grnt_o(g4[1]), .m2_grnt_o(g4[2]), .m3_grnt_o(g4[3]),
    .grnt_idx_o(idx4), .grnt_vld_o(vld4)
  );

  bus_arbiter #(.HOLD_MAX(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(req[0]), .m1_req_i(req[1]), .m2_req_i(req[2]), .m3_req_i(req[3]),
    .bus_rdy_i(rdy),
    .m0_grnt_o(g0[0]), .m1_grnt_o(g0[1]), .m2_grnt_o(g0[2]), .m3_grnt_o(g0[3]),
    .grnt_idx_o(idx0), .grnt_vld_o(vld0)
  );

  // Free-running bus clock.
  always #5 clk = ~clk;

  function automatic int rrWinner(input logic [3:0] r, input int from);
    int i;
    for (int k = 1; k <= 4; k++) begin
      i = (from + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      mOwner[d] = -1;
      mLast[d]  = 3;
      mCnt[d]   = 0;
    end
  endfunction

  function automatic void modelStep(input logic [3:0] r, input logic b);
    logic [3:0] others;
    int         w;
    for (int d = 0; d < 2; d++) begin
      if (mOwner[d] < 0) begin
        w = rrWinner(r, mLast[d]);
        if (w >= 0) begin
          mOwner[d] = w;
          mLast[d]  = w;
          mCnt[d]   = 0;
        end
      end else begin
        others = r;
        others[mOwner[d]] = 1'b0;
        if (!r[mOwner[d]] ||
            (holdMax[d] != 0 && mCnt[d] == holdMax[d] && others != 4'b0 && b)) begin
          if (others != 4'b0) begin
            w = rrWinner(others, mOwner[d]);
            mOwner[d] = w;
            mLast[d]  = w;
          end else begin
            mOwner[d] = -1;
          end
          mCnt[d] = 0;
        end else if (others != 4'b0 && mCnt[d] < holdMax[d]) begin
          mCnt[d] = mCnt[d] + 1;
        end
      end
    end
  endfunction

  task automatic checkOutput(input string name, input int d, input int expOwner);
    logic [3:0] ag;
    logic [1:0] ai;
    logic       av;
    logic [3:0] eg;
    logic       ev;
    logic       ok;
    ag = (d == 0) ? g4 : g0;
    ai = (d == 0) ? idx4 : idx0;
    av = (d == 0) ? vld4 : vld0;
    ev = (expOwner >= 0);
    eg = ev ? (4'b0001 << expOwner) : 4'b0000;
    ok = (ag == eg) && (av == ev) && (!av || ai == 2'(expOwner));
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL %s inst=%0d t=%0t: got grant=%b idx=%0d vld=%0b, want grant=%b idx=%0d vld=%0b",
               name, d, $time, ag, ai, av, eg, (ev ? expOwner : 0), ev);
    end
  endtask

  task automatic modelCheck(input string name);
    checkOutput(name, 0, mOwner[0]);
    checkOutput(name, 1, mOwner[1]);
  endtask

  // One clock: DUT and model see the same sampled inputs, outputs are
  // compared on the falling edge.
  task automatic applyStimulus(input logic [3:0] r, input logic b, input string name);
    req = r;
    rdy = b;
    @(posedge clk);
    modelStep(r, b);
    @(negedge clk);
    modelCheck(name);
  endtask

  task automatic doReset();
    @(negedge clk);
    req   = 4'b0;
    rdy   = 1'b0;
    rst_n = 1'b0;
    modelReset();
    #1;
    modelCheck("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    req   = 4'b0;
    rdy   = 1'b0;
    total = 0;
    bad   = 0;
    holdMax[0] = 4;
    holdMax[1] = 0;
    modelReset();

    vecs[0] = '{4'b1111, 1'b0, 0};
    vecs[1] = '{4'b1110, 1'b0, 1};
    vecs[2] = '{4'b1100, 1'b0, 2};
    vecs[3] = '{4'b1000, 1'b0, 3};
    vecs[4] = '{4'b0000, 1'b0, -1};
    vecs[5] = '{4'b0100, 1'b0, 2};
    vecs[6] = '{4'b0000, 1'b0, -1};

    // Full contention from reset, then single requester from IDLE.
    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].req, vecs[i].rdy, "vecModel");
      checkOutput("vecTable", 0, vecs[i].expOwner);
      checkOutput("vecTable", 1, vecs[i].expOwner);
    end

    // Hold limit reached while the bus is busy, then a ready pulse.
    applyStimulus(4'b0010, 1'b0, "pre_grant");
    checkOutput("pre_m1", 0, 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1010, 1'b0, "pre_wait");
      checkOutput("pre_hold", 0, 1);
    end
    applyStimulus(4'b1010, 1'b1, "pre_rdy");
    checkOutput("pre_m3", 0, 3);
    checkOutput("pre_nolimit", 1, 1);
    applyStimulus(4'b0010, 1'b0, "pre_back");
    checkOutput("pre_m1again", 0, 1);
    applyStimulus(4'b0000, 1'b0, "pre_idle");

    // Owner releases in the cycle the preemption condition is true.
    doReset();
    applyStimulus(4'b0001, 1'b0, "rel_grant");
    for (int i = 0; i < 5; i++) applyStimulus(4'b0101, 1'b0, "rel_wait");
    applyStimulus(4'b1100, 1'b1, "rel_same");
    checkOutput("rel_m2", 0, 2);
    checkOutput("rel_m2_nolimit", 1, 2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1100, 1'b1, "rel_cnt");
      checkOutput("rel_cnt_cleared", 0, 2);
    end
    applyStimulus(4'b1100, 1'b1, "rel_cnt_full");
    checkOutput("rel_m3", 0, 3);
    applyStimulus(4'b0000, 1'b0, "rel_idle");

    // Asynchronous reset while m3 owns the bus.
    doReset();
    applyStimulus(4'b1000, 1'b0, "ar_grant");
    checkOutput("ar_m3", 0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_async", 0, -1);
    checkOutput("ar_async", 1, -1);
    modelReset();
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b1001, 1'b0, "ar_restart");
    checkOutput("ar_m0", 0, 0);
    checkOutput("ar_m0", 1, 0);
    applyStimulus(4'b0000, 1'b0, "ar_idle");

    // Preemption disabled: m0 keeps the bus through ready toggling.
    doReset();
    for (int i = 0; i < 200; i++) begin
      applyStimulus(4'b0011, 1'(i % 2), "nopre");
      checkOutput("nopre_m0", 1, 0);
    end
    applyStimulus(4'b0000, 1'b0, "nopre_idle");

    // Randomized traffic with sticky requests and random ready.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      r = req;
      for (int b = 0; b < 4; b++) begin
        if (r[b]) begin
          if ($urandom_range(0, 3) == 0) r[b] = 1'b0;
        end else begin
          if ($urandom_range(0, 2) == 0) r[b] = 1'b1;
        end
      end
      applyStimulus(r, 1'($urandom_range(0, 1)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
